// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared types and constants for the systolic array and its result drain.
//   MATRIX_SIZE   : matrix dimension N (N x N elements)
//   DATA_W        : signed element width
//   elem_t        : one signed matrix element
//   matrix_t      : full N x N result matrix, indexed [row][col]
//   drain_state_t : result drain FSM states (IDLE, STREAM)
package systolic_pkg;

  localparam int MATRIX_SIZE = 10;
  localparam int DATA_W      = 16;

  typedef logic signed [DATA_W-1:0] elem_t;

  typedef elem_t matrix_t [MATRIX_SIZE][MATRIX_SIZE];

  // Explicit encodings keep the state register layout stable for older
  // tooling that expects fixed 1-bit state constants.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Captures the full result matrix from systolic_array on a rising edge of
// 'done' and streams it out one element per valid/ready transfer in
// row-major order, tagged with row, column and last.
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst        in   asynchronous active-high reset
//   done       in   completion level/pulse from systolic_array
//   A_result   in   N x N signed result matrix, sampled only on capture
//   out_valid  out  element available
//   out_ready  in   consumer accepts the element this cycle
//   out_data   out  current element (0 when not valid)
//   out_row    out  row index of the current element
//   out_col    out  column index of the current element
//   out_last   out  current element is [N-1][N-1]
//   busy       out  a matrix is held or being streamed
//   overrun    out  sticky: a completion arrived while busy
//
// Optional build macro:
//   RESULT_SAT8_EN  clamp each streamed element to [0, 255] at the output
//                   mux; the buffer always stores raw values.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = systolic_pkg::MATRIX_SIZE,
  parameter int DATA_W      = systolic_pkg::DATA_W,
  localparam int IDX_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic signed [DATA_W-1:0] A_result [MATRIX_SIZE][MATRIX_SIZE],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_row,
  output logic [IDX_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  drain_state_t state;
  logic                     done_q;
  logic [IDX_W-1:0]         row;
  logic [IDX_W-1:0]         col;
  logic signed [DATA_W-1:0] mem [MATRIX_SIZE][MATRIX_SIZE];

  logic capture;
  logic streaming;
  logic at_last;
  logic xfer;
  logic final_xfer;
  logic load;
  logic signed [DATA_W-1:0] raw_elem;

  // A completion held high for several cycles must only count once.
  assign capture    = done & ~done_q;
  assign streaming  = (state == STREAM);
  assign at_last    = (row == LAST_IDX) && (col == LAST_IDX);
  assign xfer       = streaming & out_ready;
  assign final_xfer = xfer & at_last;

  // A new matrix is accepted when idle, or when it lands exactly on the
  // final transfer so back-to-back results stream without a gap.
  assign load = capture & (~streaming | final_xfer);

`ifdef RESULT_SAT8_EN
  function automatic logic signed [DATA_W-1:0] clamp_sat8(
    input logic signed [DATA_W-1:0] v
  );
    if (v < 0)
      return '0;
    else if (v > 255)
      return DATA_W'(255);
    else
      return v;
  endfunction
`endif

  // Buffer is deliberately not reset; contents are only meaningful after
  // a capture, and A_result only has to be valid in that one cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          mem[i][j] <= A_result[i][j];
        end
      end
    end
  end

  // Edge detect, FSM, row-major index walk and sticky overrun flag.
  // Captures that arrive mid-stream are dropped but recorded in overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      row     <= '0;
      col     <= '0;
      overrun <= 1'b0;
    end else begin
      done_q <= done;

      if (load) begin
        state <= STREAM;
        row   <= '0;
        col   <= '0;
      end else if (xfer) begin
        if (at_last) begin
          state <= IDLE;
          row   <= '0;
          col   <= '0;
        end else if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (capture && streaming && !final_xfer) begin
        overrun <= 1'b1;
      end
    end
  end

  // Output mux; indices only move on a transfer, so all tags and data
  // hold stable while the consumer stalls.
  assign raw_elem = mem[row][col];

  always_comb begin
    out_data = '0;
    if (streaming) begin
`ifdef RESULT_SAT8_EN
      out_data = clamp_sat8(raw_elem);
`else
      out_data = raw_elem;
`endif
    end
  end

  assign out_valid = streaming;
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = streaming & at_last;
  assign busy      = streaming;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
// Self-checking bench for systolic_result_drain. Expected elements are
// pushed to a queue when a matrix is presented and popped on each
// observed transfer. Build with RESULT_SAT8_EN to check the clamp.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int N     = 10;
  localparam int IDX_W = 4;

  typedef struct {
    logic signed [15:0] data;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;
    logic               last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             done;
  matrix_t          aMat;
  logic             out_valid;
  logic             out_ready;
  logic signed [15:0] out_data;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic             out_last;
  logic             busy;
  logic             overrun;

  exp_t    expQ[$];
  matrix_t ramp;
  matrix_t other;
  int      errors = 0;
  int      checks = 0;

  systolic_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .A_result  (aMat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic signed [15:0] model(input logic signed [15:0] v);
`ifdef RESULT_SAT8_EN
    if (v < 0) return 16'sd0;
    if (v > 255) return 16'sd255;
    return v;
`else
    return v;
`endif
  endfunction

  task automatic pushMatrix(input matrix_t m);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e.data = model(m[i][j]);
        e.row  = IDX_W'(i);
        e.col  = IDX_W'(j);
        e.last = (i == N - 1) && (j == N - 1);
        expQ.push_back(e);
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after capture.
  task automatic pulseDone(input matrix_t m);
    out_ready = 1'b0;
    aMat = m;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    done = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        aMat[i][j] = '0;
    #12;
    checks++;
    if ({out_valid, out_last, busy, overrun} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid/last/busy/overrun=%b, want 0000",
               {out_valid, out_last, busy, overrun});
    end
    checks++;
    if (out_data !== 16'sd0 || out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%0d row=%0d col=%0d, want 0/0/0",
               out_data, out_row, out_col);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_stream();
    exp_t e;
    int cyc = 0;
    pushMatrix(ramp);
    pulseDone(ramp);
    while (expQ.size() > 0 && cyc < 300) begin
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_stream_valid: got valid=%b, want 1", out_valid);
      end else begin
        e = expQ.pop_front();
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
          errors++;
          $display("[TB] FAIL full_stream_elem: got d=%0d r=%0d c=%0d l=%b, want d=%0d r=%0d c=%0d l=%b",
                   out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_stream_timeout: got %0d left, want 0", expQ.size());
      expQ.delete();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_stream_end: got busy=%b valid=%b last=%b, want 0 0 0",
               busy, out_valid, out_last);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t held;
    logic prevStall = 1'b0;
    int cyc = 0;
    pushMatrix(ramp);
    pulseDone(ramp);
    while (expQ.size() > 0 && cyc < 400) begin
      out_ready = (cyc % 3 == 0);
      if (prevStall) begin
        checks++;
        if (out_data !== held.data || out_row !== held.row || out_col !== held.col || out_last !== held.last) begin
          errors++;
          $display("[TB] FAIL stall_hold: got d=%0d r=%0d c=%0d l=%b, want d=%0d r=%0d c=%0d l=%b",
                   out_data, out_row, out_col, out_last, held.data, held.row, held.col, held.last);
        end
      end
      prevStall = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        e = expQ.pop_front();
        checks++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
          errors++;
          $display("[TB] FAIL stall_elem: got d=%0d r=%0d c=%0d l=%b, want d=%0d r=%0d c=%0d l=%b",
                   out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
      end else if (out_valid === 1'b1) begin
        held.data = out_data;
        held.row  = out_row;
        held.col  = out_col;
        held.last = out_last;
        prevStall = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_timeout: got %0d left, want 0", expQ.size());
      expQ.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    exp_t e;
    logic fired = 1'b0;
    int cyc = 0;
    pushMatrix(ramp);
    pulseDone(ramp);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_before: got %b, want 0", overrun);
    end
    while (expQ.size() > 0 && cyc < 300) begin
      out_ready = 1'b1;
      done = 1'b0;
      if (out_valid === 1'b1) begin
        e = expQ.pop_front();
        checks++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col) begin
          errors++;
          $display("[TB] FAIL overrun_elem: got d=%0d r=%0d c=%0d, want d=%0d r=%0d c=%0d",
                   out_data, out_row, out_col, e.data, e.row, e.col);
        end
        if (e.data == 16'sd37 && !fired) begin
          aMat = other;
          done = 1'b1;
          fired = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    done = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL overrun_timeout: got %0d left, want 0", expQ.size());
      expQ.delete();
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_after: got overrun=%b busy=%b, want 1 0", overrun, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_capture_on_last();
    exp_t e;
    matrix_t sevens;
    logic fired = 1'b0;
    logic justCap = 1'b0;
    int cyc = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sevens[i][j] = 16'sd7;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    pushMatrix(ramp);
    pulseDone(ramp);
    while (expQ.size() > 0 && cyc < 400) begin
      out_ready = 1'b1;
      done = 1'b0;
      if (justCap) begin
        checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b0 || out_data !== 16'sd7 || out_row !== '0 || out_col !== '0) begin
          errors++;
          $display("[TB] FAIL back_to_back: got valid=%b overrun=%b d=%0d r=%0d c=%0d, want 1 0 7 0 0",
                   out_valid, overrun, out_data, out_row, out_col);
        end
        justCap = 1'b0;
      end
      if (out_valid === 1'b1) begin
        e = expQ.pop_front();
        checks++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
          errors++;
          $display("[TB] FAIL b2b_elem: got d=%0d r=%0d c=%0d l=%b, want d=%0d r=%0d c=%0d l=%b",
                   out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
        if (e.last && !fired) begin
          aMat = sevens;
          done = 1'b1;
          pushMatrix(sevens);
          fired = 1'b1;
          justCap = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    done = 1'b0;
    checks++;
    if (expQ.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got left=%0d busy=%b, want 0 0", expQ.size(), busy);
      expQ.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    matrix_t fresh;
    int cyc = 0;
    int popped = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        fresh[i][j] = 16'(1000 + 10 * i + j);
    pushMatrix(ramp);
    pulseDone(ramp);
    while (popped < 50 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = expQ.pop_front();
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd50) begin
      errors++;
      $display("[TB] FAIL abort_pre: got valid=%b d=%0d, want 1 50", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'sd0 || out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("[TB] FAIL abort_now: got valid=%b busy=%b d=%0d r=%0d c=%0d, want 0 0 0 0 0",
               out_valid, busy, out_data, out_row, out_col);
    end
    #1;
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    pushMatrix(fresh);
    pulseDone(fresh);
    cyc = 0;
    while (expQ.size() > 0 && cyc < 300) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = expQ.pop_front();
        checks++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col) begin
          errors++;
          $display("[TB] FAIL restart_elem: got d=%0d r=%0d c=%0d, want d=%0d r=%0d c=%0d",
                   out_data, out_row, out_col, e.data, e.row, e.col);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_timeout: got %0d left, want 0", expQ.size());
      expQ.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    exp_t e;
    matrix_t satMat;
    int cyc = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        satMat[i][j] = 16'(i * 40 - j * 30);
    satMat[0][0] = -16'sd5;
    satMat[0][1] = 16'sd300;
    satMat[0][2] = 16'sd128;
    pushMatrix(satMat);
    pulseDone(satMat);
    while (expQ.size() > 0 && cyc < 300) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = expQ.pop_front();
        checks++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col) begin
          errors++;
          $display("[TB] FAIL sat_elem: got d=%0d r=%0d c=%0d, want d=%0d r=%0d c=%0d",
                   out_data, out_row, out_col, e.data, e.row, e.col);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sat_timeout: got %0d left, want 0", expQ.size());
      expQ.delete();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ramp[i][j]  = 16'(10 * i + j);
        other[i][j] = 16'(500 + i);
      end
    end
    test_reset();
    test_full_stream();
    test_stall();
    test_overrun();
    test_capture_on_last();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result-side companion to `systolic_array`. When the array signals completion, it captures the full `A_result` matrix into an internal buffer. It then streams the elements out one per transfer, in row-major order, over a valid/ready handshake with row, column and last tags. It sits between the array and any downstream consumer (DMA, UART bridge, host FIFO), so no consumer needs to read a 10×10 parallel bus.

## Interface
Parameters:
- `MATRIX_SIZE`, 10, matrix dimension N (N×N elements).
- `DATA_W`, 16, signed element width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `done`  in  1  completion level/pulse from `systolic_array`.
- `A_result`  in  DATA_W signed [N][N]  result matrix from `systolic_array`.
- `out_valid`  out  1  element available.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_data`  out  DATA_W signed  current element.
- `out_row`  out  $clog2(N)  row index of the current element.
- `out_col`  out  $clog2(N)  column index of the current element.
- `out_last`  out  1  current element is [N-1][N-1].
- `busy`  out  1  a matrix is held or being streamed.
- `overrun`  out  1  sticky: a completion arrived while busy.

## Operation
- Rising-edge detect on `done`, using a registered copy `done_q`. `capture = done & ~done_q`. A level held high counts once.
- FSM states: IDLE and STREAM.
- IDLE + capture:
  - copy all N×N elements of `A_result` into the buffer;
  - row = col = 0;
  - go to STREAM.
- STREAM:
  - `out_valid` = 1.
  - Transfer occurs when `out_valid & out_ready`.
  - On transfer: col++. When col = N-1, col wraps to 0 and row++.
  - Transfer at [N-1][N-1] returns the FSM to IDLE.
- capture while in STREAM, not coinciding with the final transfer:
  - ignored; the buffer and indices are unchanged;
  - `overrun` is set to 1.
- capture in the same cycle as the final transfer:
  - new matrix is captured;
  - indices reset to 0 and the FSM stays in STREAM;
  - `overrun` is not set.
- Output rules:
  - `out_data = buf[row][col]` when `out_valid`, otherwise 0.
  - `out_last = out_valid & (row == N-1) & (col == N-1)`.
  - `busy` = (state == STREAM).
- Stall (`out_valid & ~out_ready`): `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- `overrun` clears only on `rst`.

## Timing
- Reset values:
  - state IDLE;
  - `out_valid`, `out_last`, `busy`, `overrun` all 0;
  - `out_data`, `out_row`, `out_col` all 0;
  - `done_q` 0.
  - Buffer contents are not reset.
- Latency: capture sampled at edge t; `out_valid` is high after edge t.
- Throughput: one element per cycle while `out_ready` = 1. With continuous ready, N² cycles from first valid to the last transfer.
- After the final transfer, `out_valid` = 0 in the next cycle, unless a simultaneous capture occurred.
- `A_result` only needs to be valid in the cycle where capture is sampled.
- Asserting `rst` mid-stream aborts immediately (asynchronous). `out_valid` drops without a handshake, and a partial stream is never resumed.

## Configuration
- `RESULT_SAT8_EN` defined: each streamed element is clamped to [0, 255]. Negative values give 0 and values above 255 give 255. `out_data[DATA_W-1:8]` = 0.
- `RESULT_SAT8_EN` undefined: the raw signed DATA_W value passes through unchanged.
- In both cases the clamp applies at the output mux; the buffer stores raw values.

## Structure
- Shared package `systolic_pkg`:
  - `MATRIX_SIZE` and `DATA_W` constants;
  - `elem_t` (signed [DATA_W-1:0]);
  - `matrix_t` (elem_t [N][N]);
  - `drain_state_t` enum {IDLE, STREAM}.
- No sub-module is warranted. The edge detect, indices, buffer and FSM stay in one module.

## Test plan
- Reset, then `done` pulse with `A_result[i][j] = 10*i + j`, `out_ready` held 1 → 100 transfers carrying values 0, 1, …, 99. `out_last` is high only on value 99. `busy` goes low the cycle after the final transfer.
- Same matrix with `out_ready` toggling 1,0,0,1,… → identical value sequence, and outputs stable across every stalled cycle.
- Second `done` pulse at element 37 with a different matrix → stream continues with the original values 37…99 and `overrun` = 1 afterward.
- Second matrix (all 7s) captured on the exact cycle of the final transfer → next cycle has `out_valid` = 1, `out_data` = 7, row = col = 0, and `overrun` = 0.
- `rst` asserted asynchronously mid-stream (element 50), then released and `done` pulsed again → `out_valid` falls immediately, and the new stream restarts at [0][0].
- With `RESULT_SAT8_EN`, `A_result` containing -5, 300 and 128 → outputs 0, 255 and 128. Without the macro → -5, 300 and 128.
